// File: rtl/proc_pkg.sv
// Shared pipeline definitions: memory opcodes, memory-stage FSM states and exception codes.
package proc_pkg;

  localparam logic [4:0] OP_SW = 5'b00111;
  localparam logic [4:0] OP_LW = 5'b01000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // Cause code the writeback stage loads into rstatus ($r30) on a memory timeout.
  localparam logic [31:0] EXC_MEM_TIMEOUT = 32'd1;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-cycle down-counter: clear reloads TIMEOUT-1, tc flags the last permitted wait cycle.
module mem_wait_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= CNT_W'(TIMEOUT - 1);
    end else if (enable && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign tc = enable && (r_count == '0);

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller between the XM and MW latches; issues lw/sw over a req/ready handshake.
// Optional wait timeout with exception enabled by defining MEM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no transaction; non-mem ops pass through, a mem op issues its request
// WAIT  | request outstanding, pipeline stalled until mem_ready (or timeout)
// DONE  | result presented to MW latch; leaves when en=1
module mem_stage_ctrl
  import proc_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic [31:0]       insnIn,
  input  logic [31:0]       dataOIn,
  input  logic [31:0]       dataBIn,
  input  logic              validIn,
  output logic [31:0]       insnOut,
  output logic [31:0]       dataOOut,
  output logic [31:0]       dataDOut,
  output logic              validOut,
  output logic              excOut,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  mem_state_t  r_state;
  logic [31:0] r_rdata;
  logic        r_exc;

  logic        w_is_lw;
  logic        w_is_sw;
  logic        w_mem_op;
  logic        w_timeout;

  assign w_is_lw  = (insnIn[31:27] == OP_LW);
  assign w_is_sw  = (insnIn[31:27] == OP_SW);
  assign w_mem_op = validIn && (w_is_lw || w_is_sw);

`ifdef MEM_TIMEOUT_EN
  mem_wait_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (r_state != WAIT),
    .enable (r_state == WAIT),
    .tc     (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_rdata <= '0;
      r_exc   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mem_op) begin
            if (mem_ready) begin
              r_rdata <= mem_rdata;
              r_state <= DONE;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          // A ready arriving on the last permitted cycle still wins over the timeout.
          if (mem_ready) begin
            r_rdata <= mem_rdata;
            r_state <= DONE;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_exc   <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (en) begin
            r_exc   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    insnOut   = '0;
    dataOOut  = '0;
    dataDOut  = '0;
    validOut  = 1'b0;
    excOut    = 1'b0;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset) begin
      case (r_state)
        IDLE: begin
          if (w_mem_op) begin
            mem_req   = 1'b1;
            mem_we    = w_is_sw;
            mem_addr  = dataOIn[ADDR_W-1:0];
            mem_wdata = dataBIn;
            stall     = 1'b1;
          end else if (validIn) begin
            insnOut  = insnIn;
            dataOOut = dataOIn;
            validOut = 1'b1;
          end
        end
        WAIT: begin
          mem_req   = 1'b1;
          mem_we    = w_is_sw;
          mem_addr  = dataOIn[ADDR_W-1:0];
          mem_wdata = dataBIn;
          stall     = 1'b1;
        end
        DONE: begin
          insnOut  = insnIn;
          dataOOut = dataOIn;
          dataDOut = (w_is_lw && !r_exc) ? r_rdata : 32'd0;
          validOut = 1'b1;
          excOut   = r_exc;
        end
        default: ;
      endcase
    end
  end

endmodule
